port_uart_tx: RTL
=================

# port_uart_tx

Serial transmitter peripheral that plugs into one CPU memory-mapped I/O port pair and acts as the device end of the port protocol. The block consumes the CPU's port output word as a command register and drives the same port's input word as a status register. Bytes are handed over with a toggle handshake, buffered in a small FIFO, and shifted out as 8N1 asynchronous serial frames. It sits outside the core, next to the top level, with one instance per port pair that needs a UART.

## Interface
- CLOCKS_PER_BIT, 434, clock cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH_LOG2, 2, FIFO holds 2^FIFO_DEPTH_LOG2 bytes; legal range 1..7.
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- portOutput  input  32  from CPU portXOutput. Bits [7:0] are data, [8] is the request toggle, [9] is clear-overflow (level), [10] is odd-parity select (only with parity configured). Other bits are ignored.
- portInput  output  32  to CPU portXInput. Bit [0] is ackToggle, [1] fifoFull, [2] fifoEmpty, [3] txActive, [4] overflow (sticky), [15:8] fifoCount zero-extended. All other bits read 0.
- txd  output  1  serial line; idle high.

## Operation
- **Request detect:** a register `prevReq` holds the last sampled portOutput[8]. A request exists in any cycle where portOutput[8] != prevReq. `prevReq` is updated every edge.
- **On a request:**
  - If the FIFO is not full, or a pop happens on the same edge, the block pushes portOutput[7:0].
  - Otherwise the byte is dropped and overflow is set.
  - ackToggle is loaded with portOutput[8] in both cases, so software never stalls.
- **Overflow:** stays set until an edge with portOutput[9]=1. If a new overflow and a clear occur on the same edge, the set wins.
- **FIFO:** circular, with a read pointer, a write pointer, and a count of width FIFO_DEPTH_LOG2+1.
  - Pointers wrap modulo 2^FIFO_DEPTH_LOG2.
  - There is no pop from an empty FIFO and no bypass: a push into an empty FIFO cannot be popped on the same edge.
- **TX FSM** states: IDLE → START → DATA → (PARITY) → STOP.
  - IDLE: txd=1. If the FIFO is non-empty, pop into an 8-bit shifter, clear the baud counter, and go to START.
  - START: txd=0 for CLOCKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLOCKS_PER_BIT cycles. A 3-bit bit counter selects the bit.
  - STOP: txd=1 for CLOCKS_PER_BIT cycles. At the last stop cycle, if the FIFO is non-empty, pop and go straight to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- **Status outputs:**
  - txActive=1 in every state except IDLE.
  - fifoFull and fifoEmpty are decoded from count.
  - All status bits are registered or decoded from registers, never combinational from portOutput.

## Timing
- **Reset values:** txd=1, portInput=0x00000004 (fifoEmpty=1, all else 0), prevReq=0, FSM=IDLE, count=0. Pointers and counters are 0.
- **Request to ack:** the toggle changes before edge E0. The push and the ackToggle update take effect at E0, so ack is visible in the cycle after E0.
- **Ack to line:** if the FSM is in IDLE, it pops at E1 and txd falls after E1. Toggle-to-start-bit latency is 2 edges.
- **Frame length:** exactly 10×CLOCKS_PER_BIT cycles (11× with parity).
- **Baud counter:** counts 0..CLOCKS_PER_BIT-1 and advances the bit or state on terminal count.
- **Reset mid-frame:** txd goes high asynchronously, the FIFO contents are discarded, and status returns to reset values.
- **Mid-frame input changes:** changing portOutput[10] mid-frame has no effect. Parity mode is latched at pop time.

## Configuration
- `PORT_UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - Parity is even by default, or odd when the portOutput[10] value latched at pop time was 1.
  - Frame length is 11 bits.
- Undefined:
  - No PARITY state and no latch; bit [10] is ignored.
  - Frame length is 10 bits.

## Test plan
All scenarios use CLOCKS_PER_BIT=4 and FIFO_DEPTH_LOG2=2.
- **Reset:** release reset → portInput=0x00000004, txd=1, and no frame for 100 cycles.
- **Single byte:** data 0xA5 with toggle 0→1 → ackToggle=1 after 1 edge. txd low 2 edges after the toggle, then bits 1,0,1,0,0,1,0,1, then high. 40 cycles total, then txActive=0.
- **Fill and overflow:** six toggles with 0x01..0x06, one per cycle, while the first frame runs.
  - Expected: one byte is popped, 4 are buffered, and 0x06 is dropped, so fifoFull=1 and overflow=1.
  - Serial output: 0x01..0x05 back-to-back with no idle cycles.
  - Then portOutput[9]=1 for one edge → overflow=0.
- **Push on full with same-edge pop:** FIFO full at a STOP terminal edge plus a simultaneous request with 0x77 → byte accepted, count stays 4, overflow stays 0.
- **Reset mid-frame:** assert reset during DATA bit 3 → txd=1 immediately. After release, the FIFO is empty and no residual frame is sent.
- **Parity (macro defined):** 0x03 with bit10=0 → parity bit 0. 0x07 with bit10=0 → parity bit 1. 0x07 with bit10=1 → parity bit 0. Each frame is 44 cycles.

Source files
------------

// File: rtl/port_uart_tx_if.sv
// CPU port pair as seen by the UART: command word in, status word out, serial line.
// master = CPU/top-level side, slave = the UART device.
interface port_uart_tx_if;
    logic [31:0] portOutput;
    logic [31:0] portInput;
    logic        txd;

    modport master (output portOutput, input portInput, input txd);
    modport slave  (input portOutput, output portInput, output txd);
endinterface

// File: rtl/port_uart_tx.sv
// port_uart_tx: toggle-handshake byte port -> FIFO -> 8N1 serial shifter; ack 1 edge after toggle, start bit 2 edges after.
// Never stalls software: a request on a full FIFO drops the byte and sets sticky overflow. Optional parity: PORT_UART_TX_PARITY_EN.
module port_uart_tx #(
    parameter int CLOCKS_PER_BIT  = 434,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic          clock,
    input  logic          reset,
    port_uart_tx_if.slave bus
);
    localparam int                         DEPTH     = 1 << FIFO_DEPTH_LOG2;
    localparam int                         CW        = FIFO_DEPTH_LOG2 + 1;
    localparam logic [15:0]                BAUD_LAST = 16'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0]              FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0]              CNT_ONE   = 1;
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    state_e                     state_q, state_d;
    logic [15:0]                baud_q, baud_d;
    logic [2:0]                 bit_q, bit_d;
    logic [7:0]                 shift_q, shift_d;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]              count_q;
    logic                       prev_req_q, ack_q, ovf_q;
    logic [7:0]                 mem_q [DEPTH];
    logic [7:0]                 cnt_ext;
    logic                       req, fifo_full, fifo_empty, push, pop, baud_last, ovf_set;
`ifdef PORT_UART_TX_PARITY_EN
    logic                       par_odd_q, par_odd_d;
    logic                       unused_port_bits;
    assign unused_port_bits = ^bus.portOutput[31:11];
`else
    logic                       unused_port_bits;
    assign unused_port_bits = ^bus.portOutput[31:10];
`endif

    assign req        = bus.portOutput[8] ^ prev_req_q;
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign baud_last  = (baud_q == BAUD_LAST);
    // A same-edge pop frees the slot, so a full FIFO still accepts the byte.
    assign push       = req & (~fifo_full | pop);
    assign ovf_set    = req & fifo_full & ~pop;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef PORT_UART_TX_PARITY_EN
        par_odd_d = par_odd_q;
`endif
        if (state_q != S_IDLE) baud_d = baud_last ? '0 : baud_q + 16'd1;
        unique case (state_q)
            S_IDLE:   if (!fifo_empty) pop = 1'b1;
            S_START:  if (baud_last) begin
                state_d = S_DATA;
                bit_d   = '0;
            end
            S_DATA:   if (baud_last) begin
                bit_d = bit_q + 3'd1;
`ifdef PORT_UART_TX_PARITY_EN
                if (bit_q == 3'd7) state_d = S_PARITY;
`else
                if (bit_q == 3'd7) state_d = S_STOP;
`endif
            end
            S_PARITY: if (baud_last) state_d = S_STOP;
            S_STOP:   if (baud_last) begin
                if (!fifo_empty) pop = 1'b1;
                else             state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
        if (pop) begin
            state_d = S_START;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = mem_q[rd_ptr_q];
`ifdef PORT_UART_TX_PARITY_EN
            par_odd_d = bus.portOutput[10];
`endif
        end
    end

    always_comb begin
        bus.txd = 1'b1;
        case (state_q)
            S_START:  bus.txd = 1'b0;
            S_DATA:   bus.txd = shift_q[bit_q];
`ifdef PORT_UART_TX_PARITY_EN
            S_PARITY: bus.txd = (^shift_q) ^ par_odd_q;
`endif
            default:  bus.txd = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            prev_req_q <= 1'b0;
            ack_q      <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef PORT_UART_TX_PARITY_EN
            par_odd_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            prev_req_q <= bus.portOutput[8];
`ifdef PORT_UART_TX_PARITY_EN
            par_odd_q  <= par_odd_d;
`endif
            if (req) ack_q <= bus.portOutput[8];
            if (ovf_set)               ovf_q <= 1'b1;
            else if (bus.portOutput[9]) ovf_q <= 1'b0;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= bus.portOutput[7:0];
    end

    always_comb begin
        cnt_ext           = '0;
        cnt_ext[CW-1:0]   = count_q;
    end

    assign bus.portInput = {16'h0000, cnt_ext, 3'b000, ovf_q, (state_q != S_IDLE),
                            fifo_empty, fifo_full, ack_q};
endmodule
